// File: rtl/npu_eject_pkg.sv
// Shared types for the NI packet ejection path.
package npu_eject_pkg;

    localparam int FLIT_TYPE_W = 2;

    typedef enum logic [FLIT_TYPE_W-1:0] {
        FT_HEAD     = 2'd0,
        FT_BODY     = 2'd1,
        FT_TAIL     = 2'd2,
        FT_HEADTAIL = 2'd3
    } flit_type_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_DROP,
        ST_DELIVER
    } eject_state_t;

endpackage

// File: rtl/eject_header_check.sv
// Flit type decode and destination match; macro EJECTOR_ADDR_CHECK_EN
// enables the coordinate compare, otherwise every head matches.
`include "npu_network_defines.sv"

module eject_header_check
    import npu_eject_pkg::*;
#(
    parameter int FLIT_W    = 64,
    parameter int MY_X_ADDR = 0,
    parameter int MY_Y_ADDR = 0
) (
    input  logic [FLIT_W-1:0] flit_in,
    output flit_type_t        flit_type,
    output logic              addr_match
);

    localparam int XW = `TOT_X_NODE_W;
    localparam int YW = `TOT_Y_NODE_W;
    localparam int AW = XW + YW;

    assign flit_type = flit_type_t'(flit_in[FLIT_W-1 -: FLIT_TYPE_W]);

`ifdef EJECTOR_ADDR_CHECK_EN
    logic [XW-1:0] dest_x;
    logic [YW-1:0] dest_y;
    logic          unused_payload;

    assign dest_x = flit_in[XW-1:0];
    assign dest_y = flit_in[AW-1:XW];
    assign addr_match = (dest_x == XW'(MY_X_ADDR))
                     && (dest_y == YW'(MY_Y_ADDR));
    assign unused_payload = ^flit_in[FLIT_W-3:AW];
`else
    logic unused_payload;

    assign addr_match = 1'b1;
    assign unused_payload = ^flit_in[FLIT_W-3:0];
`endif

endmodule

// File: rtl/npu_network_defines.sv
// Network-wide node coordinate field widths shared by routers and NIs.
`ifndef NPU_NETWORK_DEFINES_SV
`define NPU_NETWORK_DEFINES_SV
`define TOT_X_NODE_W 4
`define TOT_Y_NODE_W 4
`endif

// File: rtl/network_packet_ejector.sv
// Reassembles locally delivered flits into one packet for the core side.
// Address checking is compiled in with EJECTOR_ADDR_CHECK_EN.
module network_packet_ejector
    import npu_eject_pkg::*;
#(
    parameter int MY_X_ADDR = 0,
    parameter int MY_Y_ADDR = 0,
    parameter int FLIT_W    = 64,
    parameter int MAX_FLITS = 4,
    parameter int PAYLOAD_W = FLIT_W - 2,
    parameter int CW        = $clog2(MAX_FLITS + 1)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           flit_in_valid,
    input  logic [FLIT_W-1:0]              flit_in,
    output logic                           flit_in_ready,
    output logic                           packet_valid,
    output logic [MAX_FLITS*PAYLOAD_W-1:0] packet_data,
    output logic [CW-1:0]                  packet_len,
    input  logic                           packet_ready,
    output logic                           err_misroute,
    output logic                           err_overflow,
    output logic                           err_protocol
);

    eject_state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [MAX_FLITS-1:0][PAYLOAD_W-1:0] slot_q, slot_d;
    logic ovf_q, ovf_d;
    logic pro_q, pro_d;
    logic mis_d;

    flit_type_t ftype;
    logic       addr_match;
    logic       fire;
    logic       is_head;
    logic       is_end;

    eject_header_check #(
        .FLIT_W    (FLIT_W),
        .MY_X_ADDR (MY_X_ADDR),
        .MY_Y_ADDR (MY_Y_ADDR)
    ) u_hdr (
        .flit_in    (flit_in),
        .flit_type  (ftype),
        .addr_match (addr_match)
    );

    assign flit_in_ready = reset && (state_q != ST_DELIVER);
    assign fire          = flit_in_valid && flit_in_ready;
    assign is_head       = (ftype == FT_HEAD) || (ftype == FT_HEADTAIL);
    assign is_end        = (ftype == FT_TAIL) || (ftype == FT_HEADTAIL);

    assign packet_valid  = (state_q == ST_DELIVER);
    assign packet_len    = packet_valid ? cnt_q : '0;
    assign packet_data   = slot_q;
    assign err_overflow  = ovf_q;
    assign err_protocol  = pro_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        slot_d  = slot_q;
        ovf_d   = 1'b0;
        pro_d   = 1'b0;
        mis_d   = 1'b0;
        if (fire) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (!is_head) pro_d = 1'b1;
                end
                ST_COLLECT: begin
                    if (is_head) begin
                        pro_d = 1'b1;
                    end else if (cnt_q < CW'(MAX_FLITS)) begin
                        for (int i = 0; i < MAX_FLITS; i++) begin
                            if (CW'(i) == cnt_q) slot_d[i] = flit_in[PAYLOAD_W-1:0];
                        end
                        cnt_d = cnt_q + 1'b1;
                        if (ftype == FT_TAIL) state_d = ST_DELIVER;
                    end else begin
                        ovf_d   = 1'b1;
                        slot_d  = '0;
                        cnt_d   = '0;
                        state_d = (ftype == FT_BODY) ? ST_DROP : ST_IDLE;
                    end
                end
                ST_DROP: begin
                    if (is_end) state_d = ST_IDLE;
                end
                default: ;
            endcase
            // A head in COLLECT restarts reception exactly as from IDLE.
            if (is_head && (state_q == ST_IDLE || state_q == ST_COLLECT)) begin
                slot_d = '0;
                cnt_d  = '0;
                if (addr_match) begin
                    slot_d[0] = flit_in[PAYLOAD_W-1:0];
                    cnt_d     = CW'(1);
                    state_d   = (ftype == FT_HEAD) ? ST_COLLECT : ST_DELIVER;
                end else begin
                    mis_d   = 1'b1;
                    state_d = (ftype == FT_HEAD) ? ST_DROP : ST_IDLE;
                end
            end
        end
        if (state_q == ST_DELIVER && packet_ready) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            slot_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            slot_q  <= '0;
            ovf_q   <= 1'b0;
            pro_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            slot_q  <= slot_d;
            ovf_q   <= ovf_d;
            pro_q   <= pro_d;
        end
    end

`ifdef EJECTOR_ADDR_CHECK_EN
    logic mis_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) mis_q <= 1'b0;
        else        mis_q <= mis_d;
    end

    assign err_misroute = mis_q;
`else
    logic unused_mis;

    assign unused_mis   = mis_d;
    assign err_misroute = 1'b0;
`endif

endmodule

// File: tb/tb_network_packet_ejector.sv
// Directed bench for network_packet_ejector at node (1,2), MAX_FLITS=4.
`include "npu_network_defines.sv"

module tb_network_packet_ejector;
    import npu_eject_pkg::*;

    localparam int FW = 64;
    localparam int PW = 62;
    localparam int MF = 4;
    localparam int CW = 3;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              flit_in_valid = 1'b0;
    logic [FW-1:0]     flit_in = '0;
    logic              flit_in_ready;
    logic              packet_valid;
    logic [MF*PW-1:0]  packet_data;
    logic [CW-1:0]     packet_len;
    logic              packet_ready = 1'b0;
    logic              err_misroute;
    logic              err_overflow;
    logic              err_protocol;

    int total = 0;
    int bad = 0;
    int mis_n = 0;
    int ovf_n = 0;
    int pro_n = 0;

    network_packet_ejector #(
        .MY_X_ADDR (1),
        .MY_Y_ADDR (2),
        .FLIT_W    (FW),
        .MAX_FLITS (MF)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .flit_in_valid (flit_in_valid),
        .flit_in       (flit_in),
        .flit_in_ready (flit_in_ready),
        .packet_valid  (packet_valid),
        .packet_data   (packet_data),
        .packet_len    (packet_len),
        .packet_ready  (packet_ready),
        .err_misroute  (err_misroute),
        .err_overflow  (err_overflow),
        .err_protocol  (err_protocol)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (err_misroute === 1'b1) mis_n++;
        if (err_overflow === 1'b1) ovf_n++;
        if (err_protocol === 1'b1) pro_n++;
    end

    function automatic logic [FW-1:0] mk(input flit_type_t t, input logic [53:0] hi,
                                         input logic [3:0] x, input logic [3:0] y);
        return {t, hi, y, x};
    endfunction

    function automatic logic [PW-1:0] sl(input int i);
        return packet_data[i*PW +: PW];
    endfunction

    task automatic send(input logic [FW-1:0] f);
        int n = 0;
        while (flit_in_ready !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 20) begin
            total++; bad++;
            $display("FAIL send_timeout ready=%b required 1", flit_in_ready);
        end
        flit_in = f;
        flit_in_valid = 1'b1;
        @(posedge clk); #1;
        flit_in_valid = 1'b0;
        flit_in = '0;
    endtask

    task automatic test_reset;
        #12;
        total++;
        if ({flit_in_ready, packet_valid, err_misroute, err_overflow, err_protocol} !== 5'b0) begin
            bad++;
            $display("FAIL reset_ctrl got=%b required 00000",
                     {flit_in_ready, packet_valid, err_misroute, err_overflow, err_protocol});
        end
        total++;
        if (packet_data !== '0 || packet_len !== '0) begin
            bad++;
            $display("FAIL reset_data len=%0d data=%h required 0", packet_len, packet_data);
        end
        @(negedge clk);
        reset = 1'b1;
        packet_ready = 1'b1;
        @(posedge clk); #1;
        total++;
        if (flit_in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_release_ready got=%b required 1", flit_in_ready);
        end
    endtask

    task automatic test_basic;
        logic [FW-1:0] a, b, c;
        int m0, o0, p0;
        a = mk(FT_HEAD, 54'h0A0A, 4'd1, 4'd2);
        b = mk(FT_BODY, 54'h0B0B, 4'd7, 4'd3);
        c = mk(FT_TAIL, 54'h0C0C, 4'd9, 4'd5);
        m0 = mis_n; o0 = ovf_n; p0 = pro_n;
        send(a);
        send(b);
        total++;
        if (packet_valid !== 1'b0) begin
            bad++;
            $display("FAIL basic_early_valid got=%b required 0", packet_valid);
        end
        send(c);
        total++;
        if (packet_valid !== 1'b1 || packet_len !== 3'd3) begin
            bad++;
            $display("FAIL basic_deliver valid=%b len=%0d required 1/3", packet_valid, packet_len);
        end
        total++;
        if (sl(0) !== a[PW-1:0] || sl(1) !== b[PW-1:0] || sl(2) !== c[PW-1:0] || sl(3) !== '0) begin
            bad++;
            $display("FAIL basic_data got=%h required %h %h %h 0", packet_data,
                     a[PW-1:0], b[PW-1:0], c[PW-1:0]);
        end
        @(posedge clk); #1;
        total++;
        if (packet_valid !== 1'b0 || flit_in_ready !== 1'b1 || packet_data !== '0) begin
            bad++;
            $display("FAIL basic_after valid=%b ready=%b required 0/1 cleared",
                     packet_valid, flit_in_ready);
        end
        total++;
        if (mis_n != m0 || ovf_n != o0 || pro_n != p0) begin
            bad++;
            $display("FAIL basic_errs got=%0d/%0d/%0d required 0/0/0",
                     mis_n - m0, ovf_n - o0, pro_n - p0);
        end
    endtask

    task automatic test_hold;
        logic [FW-1:0] d;
        d = mk(FT_HEADTAIL, 54'h3D3D3D, 4'd1, 4'd2);
        packet_ready = 1'b0;
        send(d);
        for (int i = 0; i < 5; i++) begin
            total++;
            if (packet_valid !== 1'b1 || flit_in_ready !== 1'b0 ||
                packet_len !== 3'd1 || sl(0) !== d[PW-1:0]) begin
                bad++;
                $display("FAIL hold_cycle%0d valid=%b ready=%b len=%0d s0=%h required 1/0/1/%h",
                         i, packet_valid, flit_in_ready, packet_len, sl(0), d[PW-1:0]);
            end
            @(posedge clk); #1;
        end
        packet_ready = 1'b1;
        @(posedge clk); #1;
        total++;
        if (packet_valid !== 1'b0 || flit_in_ready !== 1'b1) begin
            bad++;
            $display("FAIL hold_release valid=%b ready=%b required 0/1", packet_valid, flit_in_ready);
        end
    endtask

    task automatic test_misroute;
        logic [FW-1:0] h, b, t, ht;
        int m0;
        h  = mk(FT_HEAD, 54'h111, 4'd0, 4'd2);
        b  = mk(FT_BODY, 54'h222, 4'd0, 4'd0);
        t  = mk(FT_TAIL, 54'h333, 4'd0, 4'd0);
        ht = mk(FT_HEADTAIL, 54'h444, 4'd1, 4'd2);
        m0 = mis_n;
        send(h);
        send(b);
        send(t);
`ifdef EJECTOR_ADDR_CHECK_EN
        total++;
        if (packet_valid !== 1'b0 || mis_n - m0 != 1) begin
            bad++;
            $display("FAIL misroute_drop valid=%b pulses=%0d required 0/1", packet_valid, mis_n - m0);
        end
`else
        total++;
        if (packet_valid !== 1'b1 || packet_len !== 3'd3 || sl(0) !== h[PW-1:0]) begin
            bad++;
            $display("FAIL misroute_nocheck valid=%b len=%0d required 1/3", packet_valid, packet_len);
        end
        @(posedge clk); #1;
        total++;
        if (mis_n != m0) begin
            bad++;
            $display("FAIL misroute_tied got=%0d required 0", mis_n - m0);
        end
`endif
        send(ht);
        total++;
        if (packet_valid !== 1'b1 || packet_len !== 3'd1 || sl(0) !== ht[PW-1:0] || sl(1) !== '0) begin
            bad++;
            $display("FAIL misroute_next valid=%b len=%0d s0=%h required 1/1/%h",
                     packet_valid, packet_len, sl(0), ht[PW-1:0]);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_overflow;
        logic [FW-1:0] ht;
        int o0, p0;
        ht = mk(FT_HEADTAIL, 54'h55, 4'd1, 4'd2);
        o0 = ovf_n; p0 = pro_n;
        send(mk(FT_HEAD, 54'h1, 4'd1, 4'd2));
        for (int i = 0; i < 3; i++) send(mk(FT_BODY, 54'(i), 4'd0, 4'd0));
        total++;
        if (err_overflow !== 1'b0) begin
            bad++;
            $display("FAIL ovf_early got=%b required 0", err_overflow);
        end
        send(mk(FT_BODY, 54'h99, 4'd0, 4'd0));
        total++;
        if (err_overflow !== 1'b1) begin
            bad++;
            $display("FAIL ovf_pulse got=%b required 1", err_overflow);
        end
        send(mk(FT_TAIL, 54'h77, 4'd0, 4'd0));
        total++;
        if (packet_valid !== 1'b0 || ovf_n - o0 != 1) begin
            bad++;
            $display("FAIL ovf_nodeliver valid=%b pulses=%0d required 0/1", packet_valid, ovf_n - o0);
        end
        send(ht);
        total++;
        if (packet_valid !== 1'b1 || packet_len !== 3'd1 || pro_n != p0) begin
            bad++;
            $display("FAIL ovf_idle valid=%b len=%0d proto=%0d required 1/1/0",
                     packet_valid, packet_len, pro_n - p0);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_protocol;
        logic [FW-1:0] e, f;
        int p0;
        e = mk(FT_HEAD, 54'hEEEE, 4'd1, 4'd2);
        f = mk(FT_TAIL, 54'hFFFF, 4'd6, 4'd6);
        p0 = pro_n;
        send(mk(FT_BODY, 54'h12, 4'd0, 4'd0));
        total++;
        if (err_protocol !== 1'b1 || packet_valid !== 1'b0) begin
            bad++;
            $display("FAIL proto_lone err=%b valid=%b required 1/0", err_protocol, packet_valid);
        end
        send(mk(FT_HEAD, 54'h21, 4'd1, 4'd2));
        send(mk(FT_BODY, 54'h22, 4'd0, 4'd0));
        send(e);
        total++;
        if (err_protocol !== 1'b1) begin
            bad++;
            $display("FAIL proto_rehead got=%b required 1", err_protocol);
        end
        send(f);
        total++;
        if (packet_valid !== 1'b1 || packet_len !== 3'd2 || sl(0) !== e[PW-1:0] ||
            sl(1) !== f[PW-1:0] || sl(2) !== '0 || sl(3) !== '0) begin
            bad++;
            $display("FAIL proto_deliver len=%0d data=%h required 2 %h %h", packet_len,
                     packet_data, e[PW-1:0], f[PW-1:0]);
        end
        total++;
        if (pro_n - p0 != 2) begin
            bad++;
            $display("FAIL proto_count got=%0d required 2", pro_n - p0);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid;
        logic [FW-1:0] g;
        int m0, o0, p0;
        g = mk(FT_HEADTAIL, 54'h6060, 4'd1, 4'd2);
        send(mk(FT_HEAD, 54'h31, 4'd1, 4'd2));
        send(mk(FT_BODY, 54'h32, 4'd0, 4'd0));
        m0 = mis_n; o0 = ovf_n; p0 = pro_n;
        #2;
        reset = 1'b0;
        #1;
        total++;
        if ({flit_in_ready, packet_valid, err_misroute, err_overflow, err_protocol} !== 5'b0 ||
            packet_data !== '0 || packet_len !== '0) begin
            bad++;
            $display("FAIL midreset_outputs ctrl=%b len=%0d required 0",
                     {flit_in_ready, packet_valid, err_misroute, err_overflow, err_protocol},
                     packet_len);
        end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        send(g);
        total++;
        if (packet_valid !== 1'b1 || packet_len !== 3'd1 || sl(0) !== g[PW-1:0] ||
            sl(1) !== '0 || sl(2) !== '0 || sl(3) !== '0) begin
            bad++;
            $display("FAIL midreset_fresh valid=%b len=%0d data=%h required 1/1/%h",
                     packet_valid, packet_len, packet_data, g[PW-1:0]);
        end
        total++;
        if (mis_n != m0 || ovf_n != o0 || pro_n != p0) begin
            bad++;
            $display("FAIL midreset_errs got=%0d/%0d/%0d required 0/0/0",
                     mis_n - m0, ovf_n - o0, pro_n - p0);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset;
        test_basic;
        test_hold;
        test_misroute;
        test_overflow;
        test_protocol;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
